// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: walks one image frame through the convolution datapath.
// It buffers pixel words from the micro into frame memory and starts the conv core
// with the latched kernel. When the core finishes, it streams result words back
// one get strobe at a time.
// Optional build macro: CONV_TIMEOUT_EN adds a watchdog on the wait for conv completion.
module conv_frame_sequencer #(
    parameter int NB_DATA      = 24,
    parameter int NB_ADDR      = 10,
    parameter int FRAME_WORDS  = 1024,
    parameter int CONV_TIMEOUT = 65535
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_pixel,
    input  logic               i_end_frame,
    input  logic [1:0]         i_kernel_sel,
    input  logic               i_get_frame,
    output logic               o_mem_wr_en,
    output logic [NB_ADDR-1:0] o_mem_wr_addr,
    output logic [NB_DATA-1:0] o_mem_wr_data,
    output logic               o_conv_start,
    output logic [1:0]         o_conv_kernel,
    input  logic               i_conv_done,
    output logic               o_mem_rd_en,
    output logic [NB_ADDR-1:0] o_mem_rd_addr,
    input  logic [NB_DATA-1:0] i_mem_rd_data,
    output logic [NB_DATA-1:0] o_frame_out,
    output logic               o_frame_valid,
    output logic               o_frame_ready,
    output logic               o_busy,
    output logic               o_error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV_START,
        CONV_WAIT,
        READOUT
    } state_t;

    // Counters need one extra bit so that a completely full frame (FRAME_WORDS) can be represented.
    localparam int CNT_W = NB_ADDR + 1;
    localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_WORDS);

    state_t           state;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] frame_len;
    logic             rd_capture;
    logic             has_room;
    logic             rd_last;

`ifdef CONV_TIMEOUT_EN
    localparam int TO_W = $clog2(CONV_TIMEOUT + 1);
    logic [TO_W-1:0] timeout_cnt;
`endif

    assign has_room = (wr_cnt < FRAME_MAX);
    assign rd_last  = (rd_cnt == (frame_len - CNT_W'(1)));

    // Frame sequencing FSM; every output is driven from a register in this block.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            frame_len     <= '0;
            rd_capture    <= 1'b0;
            o_mem_wr_en   <= 1'b0;
            o_mem_wr_addr <= '0;
            o_mem_wr_data <= '0;
            o_conv_start  <= 1'b0;
            o_conv_kernel <= '0;
            o_mem_rd_en   <= 1'b0;
            o_mem_rd_addr <= '0;
            o_frame_out   <= '0;
            o_frame_valid <= 1'b0;
            o_frame_ready <= 1'b0;
            o_busy        <= 1'b0;
            o_error       <= 1'b0;
`ifdef CONV_TIMEOUT_EN
            timeout_cnt   <= '0;
`endif
        end else begin
            o_mem_wr_en   <= 1'b0;
            o_conv_start  <= 1'b0;
            o_mem_rd_en   <= 1'b0;
            o_frame_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_load) begin
                        o_mem_wr_en   <= 1'b1;
                        o_mem_wr_addr <= '0;
                        o_mem_wr_data <= i_pixel;
                        wr_cnt        <= CNT_W'(1);
                        o_error       <= 1'b0;
                        o_busy        <= 1'b1;
                        state         <= LOAD;
                    end
                end

                LOAD: begin
                    if (i_load) begin
                        if (has_room) begin
                            o_mem_wr_en   <= 1'b1;
                            o_mem_wr_addr <= wr_cnt[NB_ADDR-1:0];
                            o_mem_wr_data <= i_pixel;
                            wr_cnt        <= wr_cnt + CNT_W'(1);
                        end else begin
                            o_error <= 1'b1;
                        end
                    end
                    if (i_end_frame) begin
                        frame_len     <= (i_load && has_room) ? (wr_cnt + CNT_W'(1)) : wr_cnt;
                        o_conv_kernel <= i_kernel_sel;
                        o_conv_start  <= 1'b1;
                        state         <= CONV_START;
                    end
                end

                CONV_START: begin
                    if (i_load || i_end_frame) begin
                        o_error <= 1'b1;
                    end
`ifdef CONV_TIMEOUT_EN
                    timeout_cnt <= '0;
`endif
                    state <= CONV_WAIT;
                end

                CONV_WAIT: begin
                    if (i_load || i_end_frame) begin
                        o_error <= 1'b1;
                    end
                    if (i_conv_done) begin
                        rd_cnt        <= '0;
                        rd_capture    <= 1'b0;
                        o_frame_ready <= 1'b1;
                        state         <= READOUT;
                    end
`ifdef CONV_TIMEOUT_EN
                    else if (timeout_cnt == TO_W'(CONV_TIMEOUT - 1)) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
`endif
                end

                READOUT: begin
                    if (i_load || i_end_frame) begin
                        o_error <= 1'b1;
                    end
                    if (rd_capture) begin
                        o_frame_out   <= i_mem_rd_data;
                        o_frame_valid <= 1'b1;
                        rd_capture    <= 1'b0;
                        if (rd_last) begin
                            o_frame_ready <= 1'b0;
                            o_busy        <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + CNT_W'(1);
                        end
                    end else if (o_mem_rd_en) begin
                        rd_capture <= 1'b1;
                    end else if (i_get_frame) begin
                        o_mem_rd_en   <= 1'b1;
                        o_mem_rd_addr <= rd_cnt[NB_ADDR-1:0];
                    end
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed testbench for conv_frame_sequencer with a small frame (8 words, 3-bit address).
// Result memory is modelled as a synchronous read returning 0xA00000 + address.
// Build with CONV_TIMEOUT_EN defined to also exercise the completion watchdog (limit 16).
module tb_conv_frame_sequencer;

    localparam int NB_DATA      = 24;
    localparam int NB_ADDR      = 3;
    localparam int FRAME_WORDS  = 8;
    localparam int CONV_TIMEOUT = 16;

    logic               clock;
    logic               reset;
    logic               i_load;
    logic [NB_DATA-1:0] i_pixel;
    logic               i_end_frame;
    logic [1:0]         i_kernel_sel;
    logic               i_get_frame;
    logic               o_mem_wr_en;
    logic [NB_ADDR-1:0] o_mem_wr_addr;
    logic [NB_DATA-1:0] o_mem_wr_data;
    logic               o_conv_start;
    logic [1:0]         o_conv_kernel;
    logic               i_conv_done;
    logic               o_mem_rd_en;
    logic [NB_ADDR-1:0] o_mem_rd_addr;
    logic [NB_DATA-1:0] i_mem_rd_data;
    logic [NB_DATA-1:0] o_frame_out;
    logic               o_frame_valid;
    logic               o_frame_ready;
    logic               o_busy;
    logic               o_error;

    int check_count = 0;
    int fail_count  = 0;

    int wr_count    = 0;
    int start_count = 0;
    int rd_count    = 0;
    int valid_count = 0;
    logic [NB_ADDR-1:0] wr_addr_log [64];
    logic [NB_DATA-1:0] wr_data_log [64];

    conv_frame_sequencer #(
        .NB_DATA     (NB_DATA),
        .NB_ADDR     (NB_ADDR),
        .FRAME_WORDS (FRAME_WORDS),
        .CONV_TIMEOUT(CONV_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_load       (i_load),
        .i_pixel      (i_pixel),
        .i_end_frame  (i_end_frame),
        .i_kernel_sel (i_kernel_sel),
        .i_get_frame  (i_get_frame),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_wr_addr(o_mem_wr_addr),
        .o_mem_wr_data(o_mem_wr_data),
        .o_conv_start (o_conv_start),
        .o_conv_kernel(o_conv_kernel),
        .i_conv_done  (i_conv_done),
        .o_mem_rd_en  (o_mem_rd_en),
        .o_mem_rd_addr(o_mem_rd_addr),
        .i_mem_rd_data(i_mem_rd_data),
        .o_frame_out  (o_frame_out),
        .o_frame_valid(o_frame_valid),
        .o_frame_ready(o_frame_ready),
        .o_busy       (o_busy),
        .o_error      (o_error)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read result memory: data follows the address one cycle after the enable.
    always @(posedge clock) begin
        if (o_mem_rd_en) begin
            i_mem_rd_data <= 24'hA00000 + NB_DATA'(o_mem_rd_addr);
        end
    end

    // Monitor: logs writes and counts pulses just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (o_mem_wr_en) begin
            if (wr_count < 64) begin
                wr_addr_log[wr_count] = o_mem_wr_addr;
                wr_data_log[wr_count] = o_mem_wr_data;
            end
            wr_count = wr_count + 1;
        end
        if (o_conv_start) start_count = start_count + 1;
        if (o_mem_rd_en)  rd_count    = rd_count + 1;
        if (o_frame_valid) valid_count = valid_count + 1;
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count = check_count + 1;
        if (observed !== expected) begin
            fail_count = fail_count + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of strobes starting at a falling edge, then returns everything idle.
    task automatic applyStimulus(input logic load, input logic [NB_DATA-1:0] pixel, input logic end_frame,
                                 input logic [1:0] sel, input logic get, input logic done);
        i_load       = load;
        i_pixel      = pixel;
        i_end_frame  = end_frame;
        i_kernel_sel = sel;
        i_get_frame  = get;
        i_conv_done  = done;
        @(negedge clock);
        i_load      = 1'b0;
        i_end_frame = 1'b0;
        i_get_frame = 1'b0;
        i_conv_done = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Requests one result word and checks latency, data and the ready level afterwards.
    task automatic readWord(input int k, input logic exp_ready);
        int cycles;
        logic seen;
        cycles = 0;
        seen   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            cycles = cycles + 1;
            if (o_frame_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("valid_seen", 32'(seen), 32'd1);
        checkOutput("rd_latency", cycles, 32'd2);
        checkOutput("frame_out", 32'(o_frame_out), 32'hA00000 + 32'(k));
        checkOutput("ready_after_word", 32'(o_frame_ready), 32'(exp_ready));
        tick(1);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int wr_base;
        int rd_base;
        int valid_base;
        int start_base;

        reset        = 1'b0;
        i_load       = 1'b0;
        i_pixel      = '0;
        i_end_frame  = 1'b0;
        i_kernel_sel = 2'b00;
        i_get_frame  = 1'b0;
        i_conv_done  = 1'b0;
        tick(3);

        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_error", 32'(o_error), 32'd0);
        checkOutput("rst_ready", 32'(o_frame_ready), 32'd0);
        checkOutput("rst_wr_en", 32'(o_mem_wr_en), 32'd0);
        checkOutput("rst_kernel", 32'(o_conv_kernel), 32'd0);
        checkOutput("rst_frame_out", 32'(o_frame_out), 32'd0);
        reset = 1'b1;
        tick(1);

        $display("[TB] load four words, kernel 3");
        wr_base    = wr_count;
        start_base = start_count;
        applyStimulus(1'b1, 24'h000011, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h000022, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h000033, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h000044, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 2'b11, 1'b0, 1'b0);
        checkOutput("conv_start_pulse", 32'(o_conv_start), 32'd1);
        tick(2);
        checkOutput("t1_writes", wr_count - wr_base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_wr_addr", 32'(wr_addr_log[wr_base + i]), 32'(i));
            checkOutput("t1_wr_data", 32'(wr_data_log[wr_base + i]), 32'h11 * 32'(i + 1));
        end
        checkOutput("t1_starts", start_count - start_base, 32'd1);
        checkOutput("t1_kernel", 32'(o_conv_kernel), 32'd3);
        checkOutput("t1_busy", 32'(o_busy), 32'd1);
        checkOutput("t1_ready_before_done", 32'(o_frame_ready), 32'd0);

        $display("[TB] conv done and read four words");
        rd_base    = rd_count;
        valid_base = valid_count;
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("t2_ready", 32'(o_frame_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            readWord(k, (k < 3) ? 1'b1 : 1'b0);
        end
        checkOutput("t2_reads", rd_count - rd_base, 32'd4);
        checkOutput("t2_valids", valid_count - valid_base, 32'd4);
        checkOutput("t2_busy", 32'(o_busy), 32'd0);
        checkOutput("t2_frame_out_held", 32'(o_frame_out), 32'hA00003);

        $display("[TB] overflow: nine loads into an eight word frame");
        wr_base = wr_count;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 24'h000100 + NB_DATA'(i), 1'b0, 2'b00, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 2'b01, 1'b0, 1'b0);
        tick(1);
        checkOutput("t3_writes", wr_count - wr_base, 32'd8);
        checkOutput("t3_last_addr", 32'(wr_addr_log[wr_base + 7]), 32'd7);
        checkOutput("t3_last_data", 32'(wr_data_log[wr_base + 7]), 32'h107);
        checkOutput("t3_error", 32'(o_error), 32'd1);
        checkOutput("t3_kernel", 32'(o_conv_kernel), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            readWord(k, (k < 7) ? 1'b1 : 1'b0);
        end
        checkOutput("t3_busy", 32'(o_busy), 32'd0);

        $display("[TB] protocol error in CONV_WAIT and back-to-back gets");
        wr_base = wr_count;
        applyStimulus(1'b1, 24'h000201, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("t4_error_cleared", 32'(o_error), 32'd0);
        applyStimulus(1'b1, 24'h000202, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 2'b00, 1'b0, 1'b0);
        tick(2);
        applyStimulus(1'b1, 24'h0002FF, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1);
        checkOutput("t4_error", 32'(o_error), 32'd1);
        checkOutput("t4_writes", wr_count - wr_base, 32'd2);
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
        rd_base    = rd_count;
        valid_base = valid_count;
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick(4);
        checkOutput("t4_reads", rd_count - rd_base, 32'd1);
        checkOutput("t4_valids", valid_count - valid_base, 32'd1);
        checkOutput("t4_frame_out", 32'(o_frame_out), 32'hA00000);
        checkOutput("t4_ready", 32'(o_frame_ready), 32'd1);
        readWord(1, 1'b0);
        checkOutput("t4_busy", 32'(o_busy), 32'd0);

        $display("[TB] conv done while idle");
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(1);
        checkOutput("idle_done_busy", 32'(o_busy), 32'd0);
        checkOutput("idle_done_ready", 32'(o_frame_ready), 32'd0);

        $display("[TB] reset during load");
        applyStimulus(1'b1, 24'h000301, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h000302, 1'b0, 2'b00, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_busy", 32'(o_busy), 32'd0);
        checkOutput("t5_wr_en", 32'(o_mem_wr_en), 32'd0);
        checkOutput("t5_wr_addr", 32'(o_mem_wr_addr), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick(1);
        wr_base = wr_count;
        applyStimulus(1'b1, 24'h000055, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1);
        checkOutput("t5_new_writes", wr_count - wr_base, 32'd1);
        checkOutput("t5_new_addr", 32'(wr_addr_log[wr_base]), 32'd0);
        checkOutput("t5_new_data", 32'(wr_data_log[wr_base]), 32'h55);
        checkOutput("t5_busy_again", 32'(o_busy), 32'd1);

`ifdef CONV_TIMEOUT_EN
        $display("[TB] completion watchdog");
        applyStimulus(1'b0, '0, 1'b1, 2'b10, 1'b0, 1'b0);
        tick(16);
        checkOutput("t6_busy_before", 32'(o_busy), 32'd1);
        checkOutput("t6_error_before", 32'(o_error), 32'd0);
        tick(1);
        checkOutput("t6_busy_after", 32'(o_busy), 32'd0);
        checkOutput("t6_error_after", 32'(o_error), 32'd1);
        checkOutput("t6_ready_after", 32'(o_frame_ready), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
